demux_8x1_rr_collector: RTL and testbench

- Inverse of the team's 1x8 demux: merges eight independent source lanes onto one output lane.
- Arbitration is round-robin across the requesting sources.
- Each output word carries the 3-bit index of its source, so a downstream 1x8 demux can route it back by `sel`.
- Sits between eight producer blocks and one shared consumer.
- Uses a one-deep registered output stage with valid/ready handshakes on both sides.

---
 rtl/demux_8x1_rr_collector.sv | 63 ++++++
 tb/tb_demux_8x1_rr_collector.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/demux_8x1_rr_collector.sv
// Eight-source round-robin collector with a one-deep registered output stage.
// Each output word is tagged with its source index so a downstream demux can route it back.
module demux_8x1_rr_collector #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          in_valid,
    input  logic [8*DATA_W-1:0] in_data,
    output logic [7:0]          in_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [2:0]          out_sel,
    input  logic                out_ready
);
    logic [2:0] ptr;
    logic [2:0] gnt_idx;
    logic [2:0] idx;
    logic       gnt_any;
    logic       load_en;

    // The output register can take a new word when it is empty or being drained this cycle.
    assign load_en = !out_valid || out_ready;

    // Search ptr+1 .. ptr+8 (mod 8); the eighth step wraps back onto ptr itself.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = 3'd0;
        idx     = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            idx = ptr + 3'(k);
            if (!gnt_any && in_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        in_ready = 8'h00;
        if (!rst && load_en && gnt_any) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 3'd0;
            ptr       <= 3'd7;
        end else if (load_en) begin
            if (gnt_any) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(gnt_idx)*DATA_W +: DATA_W];
                out_sel   <= gnt_idx;
                ptr       <= gnt_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_demux_8x1_rr_collector.sv
// Directed bench for the 8x1 round-robin collector: stimulus queues expected words,
// a negedge monitor pops and compares every output transfer.
module tb_demux_8x1_rr_collector;
    localparam int DATA_W = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [7:0]          in_valid;
    logic [8*DATA_W-1:0] in_data;
    logic [7:0]          in_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [2:0]          out_sel;
    logic                out_ready;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];

    demux_8x1_rr_collector #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Source i always drives 8'hA0+i, so the expected word follows from the index.
    task automatic push(input int s);
        logic [7:0] d;
        d = 8'hA0 + 8'(s);
        exp_q.push_back({3'(s), d});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: sample at negedge, so the handshake seen here is the one the next edge commits.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got sel=%0d data=%0h expected none", out_sel, out_data);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                chk("word", {21'd0, out_sel, out_data}, {21'd0, e});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) in_data[i*DATA_W +: DATA_W] = 8'hA0 + 8'(i);
        rst = 1'b1;
        in_valid = 8'hFF;
        out_ready = 1'b1;

        // Reset with all sources requesting
        repeat (2) begin
            cyc();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_data", 32'(out_data), 32'd0);
            chk("rst_out_sel", 32'(out_sel), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) push(i);
        push(0);
        push(1);
        #1;
        chk("first_grant", 32'(in_ready), 32'h01);

        // Saturation: one word per cycle, no bubbles
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("sat_no_bubble", 32'(out_valid), 32'd1);
        end
        in_valid = 8'h00;
        cyc();
        chk("sat_drained", 32'(out_valid), 32'd0);

        // Sparse requesters after a reset pulse (ptr back to 7)
        rst = 1'b1;
        in_valid = 8'h44;
        #1;
        chk("rst_pulse_in_ready", 32'(in_ready), 32'd0);
        cyc();
        rst = 1'b0;
        push(2); push(6); push(2); push(6);
        #1;
        chk("sparse_first", 32'(in_ready), 32'h04);
        repeat (4) cyc();
        in_valid = 8'h20;
        push(5); push(5); push(5);
        #1;
        chk("single_req", 32'(in_ready), 32'h20);
        repeat (3) begin
            cyc();
            chk("single_sel", 32'(out_sel), 32'd5);
        end
        in_valid = 8'h00;
        cyc();
        chk("sparse_drained", 32'(out_valid), 32'd0);

        // Backpressure with sources 0 and 3
        in_valid = 8'h09;
        push(0); push(3); push(0);
        #1;
        chk("bp_grant0", 32'(in_ready), 32'h01);
        cyc();
        out_ready = 1'b0;
        #1;
        chk("bp_stall_in_ready", 32'(in_ready), 32'd0);
        repeat (3) begin
            cyc();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_sel", 32'(out_sel), 32'd0);
            chk("bp_hold_data", 32'(out_data), 32'hA0);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_drain_load", 32'(in_ready), 32'h08);
        cyc();
        chk("bp_sel3", 32'(out_sel), 32'd3);
        cyc();
        in_valid = 8'h00;
        cyc();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Empty drain: single word from source 4
        in_valid = 8'h10;
        push(4);
        cyc();
        in_valid = 8'h00;
        chk("one_word_valid", 32'(out_valid), 32'd1);
        chk("one_word_sel", 32'(out_sel), 32'd4);
        cyc();
        chk("one_word_gone", 32'(out_valid), 32'd0);

        // Reset while stalled: held word discarded, ptr back to 7
        in_valid = 8'hFF;
        out_ready = 1'b0;
        cyc();
        chk("mid_loaded", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        cyc();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sel", 32'(out_sel), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        push(0);
        #1;
        chk("mid_next_grant", 32'(in_ready), 32'h01);
        cyc();
        in_valid = 8'h00;
        chk("mid_word_valid", 32'(out_valid), 32'd1);
        cyc();
        chk("mid_drained", 32'(out_valid), 32'd0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
